// File: rtl/sdram_sample_writer_pkg.sv
// Shared types and constants for the SDRAM sample writer.
package sdram_sample_writer_pkg;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_ADDR_W    = 24;
  localparam int DEF_FIFO_LOG2 = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_POST,
    ST_DRAIN
  } state_e;

  // Control register offsets within the C000_00xx CPU window.
  localparam logic [31:0] REG_WINDOW     = 32'hC000_0000;
  localparam logic [7:0]  REG_CTRL       = 8'h00;  // start/abort pulses
  localparam logic [7:0]  REG_STATUS     = 8'h04;  // busy/triggered/overflow
  localparam logic [7:0]  REG_BUF_BASE   = 8'h08;
  localparam logic [7:0]  REG_BUF_LAST   = 8'h0C;
  localparam logic [7:0]  REG_POST_COUNT = 8'h10;
  localparam logic [7:0]  REG_TRIG_MASK  = 8'h14;
  localparam logic [7:0]  REG_TRIG_VALUE = 8'h18;
  localparam logic [7:0]  REG_TRIG_ADDR  = 8'h1C;
  localparam logic [7:0]  REG_WR_ADDR    = 8'h20;

endpackage

// File: rtl/sdram_sample_writer_sample_fifo.sv
// Synchronous decoupling FIFO between the pin sampler and the write channel.
// A push while full is dropped even if a pop happens in the same cycle.
module sample_fifo #(
  parameter int DATA_W    = 16,
  parameter int FIFO_LOG2 = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATA_W-1:0]    push_data,
  output logic [DATA_W-1:0]    head_data,
  output logic                 full,
  output logic                 empty,
  output logic [FIFO_LOG2:0]   count
);

  localparam int                 DEPTH   = 1 << FIFO_LOG2;
  localparam logic [FIFO_LOG2:0] CNT_MAX = DEPTH[FIFO_LOG2:0];
  localparam logic [FIFO_LOG2:0] CNT_ONE = 1;
  localparam logic [FIFO_LOG2-1:0] PTR_ONE = 1;

  logic [DATA_W-1:0]    mem_q [DEPTH];
  logic [FIFO_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_LOG2:0]   count_q, count_d;
  logic                 do_push, do_pop;

  assign full      = (count_q == CNT_MAX);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;

  // Next-state for pointers and occupancy.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array write port.
  // NOTE: the array is not reset; only the pointers need a defined state.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/sdram_sample_writer.sv
// Logic-analyser capture engine: ring-buffers strobed samples into SDRAM,
// stops a programmable number of samples after a mask/value trigger.
module sdram_sample_writer
  import sdram_sample_writer_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int FIFO_LOG2 = DEF_FIFO_LOG2
) (
  input  logic              clk_48,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_strobe,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] buf_base,
  input  logic [ADDR_W-1:0] buf_last,
  input  logic [ADDR_W-1:0] post_count,
  input  logic [DATA_W-1:0] trig_mask,
  input  logic [DATA_W-1:0] trig_value,
  output logic              busy,
  output logic              triggered,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W-1:0] trig_addr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] awaddr,
  output logic [DATA_W-1:0] wdata,
  output logic              wvalid,
  input  logic              wready
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  // Ring successor; push-side and write-side addresses wrap identically.
  function automatic logic [ADDR_W-1:0] ring_next(input logic [ADDR_W-1:0] addr,
                                                  input logic [ADDR_W-1:0] base,
                                                  input logic [ADDR_W-1:0] last);
    return (addr == last) ? base : addr + ADDR_ONE;
  endfunction

  state_e            state_q, state_d;
  logic              busy_q, busy_d, triggered_q, triggered_d, done_q, done_d;
  logic              overflow_q, overflow_d, wvalid_q, wvalid_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d, wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d, push_addr_q, push_addr_d;
  logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  // Configuration captured at start.
  logic [ADDR_W-1:0] base_q, base_d, last_q, last_d, post_q, post_d;
  logic [DATA_W-1:0] mask_q, mask_d, value_q, value_d;

  logic                fifo_clr, fifo_full, fifo_empty;
  logic [DATA_W-1:0]   fifo_head;
  logic [FIFO_LOG2:0]  fifo_count;
  logic                hs, push_en, push_ok, trig_hit;

  assign hs       = wvalid_q && wready;
  assign push_en  = sample_strobe && !abort && (state_q == ST_ARMED || state_q == ST_POST);
  assign push_ok  = push_en && !fifo_full;
  assign trig_hit = ((sample_in ^ value_q) & mask_q) == '0;

  sample_fifo #(.DATA_W(DATA_W), .FIFO_LOG2(FIFO_LOG2)) u_fifo (
    .clk       (clk_48),
    .rst_n     (rst_n),
    .clr       (fifo_clr),
    .push      (push_en),
    .pop       (hs),
    .push_data (sample_in),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Capture FSM and write-channel next-state.
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    triggered_d = triggered_q;
    done_d      = 1'b0;
    overflow_d  = overflow_q;
    trig_addr_d = trig_addr_q;
    wr_addr_d   = wr_addr_q;
    push_addr_d = push_addr_q;
    post_cnt_d  = post_cnt_q;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    wvalid_d    = wvalid_q;
    base_d      = base_q;
    last_d      = last_q;
    post_d      = post_q;
    mask_d      = mask_q;
    value_d     = value_q;
    fifo_clr    = 1'b0;

    // Write channel: present the FIFO head, hold it until accepted.
    if (hs) begin
      wvalid_d  = 1'b0;
      wr_addr_d = ring_next(wr_addr_q, base_q, last_q);
    end else if (!wvalid_q && !fifo_empty) begin
      wvalid_d = 1'b1;
      awaddr_d = wr_addr_q;
      wdata_d  = fifo_head;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_ARMED;
          busy_d      = 1'b1;
          triggered_d = 1'b0;
          overflow_d  = 1'b0;
          fifo_clr    = 1'b1;
          wr_addr_d   = buf_base;
          push_addr_d = buf_base;
          base_d      = buf_base;
          last_d      = buf_last;
          post_d      = post_count;
          mask_d      = trig_mask;
          value_d     = trig_value;
        end
      end
      ST_ARMED, ST_POST: begin
        if (abort) begin
          state_d = ST_DRAIN;
        end else if (push_en && !push_ok) begin
          overflow_d = 1'b1;
        end else if (push_ok) begin
          push_addr_d = ring_next(push_addr_q, base_q, last_q);
          if (state_q == ST_ARMED) begin
            if (trig_hit) begin
              triggered_d = 1'b1;
              trig_addr_d = push_addr_q;
              post_cnt_d  = post_q;
              state_d     = (post_q == '0) ? ST_DRAIN : ST_POST;
            end
          end else begin
            post_cnt_d = post_cnt_q - ADDR_ONE;
            if (post_cnt_q == ADDR_ONE) state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (fifo_count == '0 && !wvalid_q) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset drops wvalid immediately.
  always_ff @(posedge clk_48 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      triggered_q <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      trig_addr_q <= '0;
      wr_addr_q   <= '0;
      push_addr_q <= '0;
      post_cnt_q  <= '0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      wvalid_q    <= 1'b0;
      base_q      <= '0;
      last_q      <= '0;
      post_q      <= '0;
      mask_q      <= '0;
      value_q     <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      triggered_q <= triggered_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
      trig_addr_q <= trig_addr_d;
      wr_addr_q   <= wr_addr_d;
      push_addr_q <= push_addr_d;
      post_cnt_q  <= post_cnt_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      wvalid_q    <= wvalid_d;
      base_q      <= base_d;
      last_q      <= last_d;
      post_q      <= post_d;
      mask_q      <= mask_d;
      value_q     <= value_d;
    end
  end

  assign busy      = busy_q;
  assign triggered = triggered_q;
  assign done      = done_q;
  assign overflow  = overflow_q;
  assign trig_addr = trig_addr_q;
  assign wr_addr   = wr_addr_q;
  assign awaddr    = awaddr_q;
  assign wdata     = wdata_q;
  assign wvalid    = wvalid_q;

endmodule

// File: doc/sdram_sample_writer.md
Name: sdram_sample_writer

Overview:
Autonomous write-channel initiator for the sdram controller. Captures 16-bit logic-analyser samples from the s pins into SDRAM as a ring buffer, with a mask/value trigger and a programmable post-trigger length. The CPU programs and arms the block through the C000_00xx register space, then reads the captured data back through the existing D??????? read path. This block is the writer for that reader; it sits between the pin sampler and the sdram0 awaddr/wdata/wvalid/wready ports.

Parameters:
DATA_W, 16, sample and SDRAM word width
ADDR_W, 24, SDRAM word address width
FIFO_LOG2, 4, log2 of decoupling FIFO depth (16 entries)

Ports:
clk_48  in  1  system clock
rst_n  in  1  asynchronous active-low reset
sample_in  in  DATA_W  sample word, valid when sample_strobe=1
sample_strobe  in  1  one-cycle sample pulse
start  in  1  one-cycle arm pulse; ignored while busy=1
abort  in  1  one-cycle pulse; stop capture, drain, finish
buf_base  in  ADDR_W  first ring word address
buf_last  in  ADDR_W  last ring word address (buf_last >= buf_base)
post_count  in  ADDR_W  samples to store after the trigger sample
trig_mask  in  DATA_W  trigger bit mask; 0 means immediate trigger
trig_value  in  DATA_W  trigger compare value
busy  out  1  capture in progress
triggered  out  1  trigger seen (sticky until next start)
done  out  1  one-cycle pulse when capture completes
overflow  out  1  sticky; sample dropped because FIFO was full
trig_addr  out  ADDR_W  SDRAM address of the trigger sample
wr_addr  out  ADDR_W  next address to be written
awaddr  out  ADDR_W  to sdram awaddr
wdata  out  DATA_W  to sdram wdata
wvalid  out  1  to sdram wvalid
wready  in  1  from sdram wready

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE; every output 0; FIFO empty. Reset during an active write drops wvalid immediately; the partial buffer is abandoned.
- States: IDLE, ARMED, POST, DRAIN.
  - IDLE→ARMED on start. Latches buf_base into wr_addr. Clears triggered, overflow and the FIFO. busy=1.
  - ARMED: each strobe pushes sample_in. If (sample_in & trig_mask) == (trig_value & trig_mask), then triggered=1, trig_addr=write address of that sample, and the post counter is loaded with post_count. Go to POST, or to DRAIN if post_count=0.
  - POST: each accepted push decrements the counter. The push that reaches 0 moves the block to DRAIN. Strobes in DRAIN and IDLE are ignored.
  - abort in ARMED/POST → DRAIN. abort in DRAIN/IDLE has no effect.
  - DRAIN→IDLE when the FIFO is empty and no write is outstanding. done pulses for exactly 1 cycle on that transition; busy falls in the same cycle.
- FIFO push when full (count = 2^FIFO_LOG2) is rejected even if a pop happens in the same cycle. A rejected push sets overflow and does not decrement the post counter. A rejected trigger-matching sample does not trigger.
- Write channel (AXI-style):
  - wvalid, awaddr and wdata are registered. When wvalid=0 and the FIFO is non-empty, load the head word and wr_addr and set wvalid the next cycle.
  - awaddr and wdata are held stable while wvalid=1 && wready=0.
  - On wvalid && wready: pop the FIFO. wr_addr = (wr_addr == buf_last) ? buf_base : wr_addr+1. The next word may be presented in the following cycle (throughput 1 word per 2 cycles minimum).
- Latency: a strobe in cycle N is in the FIFO at N+1; earliest wvalid is N+2.
- Ring wrap in ARMED overwrites the oldest samples; that is legal. Trigger address arithmetic wraps identically to wr_addr.
- Push and pop in the same cycle are legal; the FIFO count is unchanged.
- buf_base/buf_last/post_count/trig_* are sampled only at start; later changes are ignored until the next start.

Decomposition:
- Shared package: state encoding (ST_IDLE..ST_DRAIN), DATA_W/ADDR_W defaults, and the C000_00xx register offsets used by main for the control registers.
- One sub-module, sample_fifo: synchronous FIFO with push/pop/full/empty/count, parameterised by DATA_W and FIFO_LOG2.

Test Plan:
- base=0x100, last=0x10F, mask=0: start, 4 strobes with wready=1 → trigger on sample 0, trig_addr=0x100, post_count=3 gives 4 writes to 0x100..0x103, done pulse, wr_addr=0x104.
- base=0, last=3, mask=0x8000, value=0x8000: 10 samples 0..9, then 0x8001, post_count=2 → writes wrap 0,1,2,3,0,…; trig_addr=2; last data 0x8001,x,x at addresses 2,3,0.
- wready held 0 for 40 cycles while 20 strobes arrive → 16 stored, overflow=1, awaddr/wdata constant while stalled; after release all 16 are written in order.
- abort in POST with 5 words queued → no further pushes, 5 writes complete, then done; busy falls with done.
- start while busy → ignored, registers unchanged. rst_n low mid-write with wvalid=1 → wvalid=0 asynchronously, all outputs 0.
- Same-cycle push and pop at FIFO full-1 and at full → count stable in the first case, push rejected in the second, overflow=1.
